// File: rtl/partition_op_arbiter.sv
// Round-robin arbiter that shares one partition_core between NUM_REQ requesters.
// Optional watchdog in WAIT is enabled by defining PARTITION_ARB_TIMEOUT_EN.
module partition_op_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int REGION_WIDTH   = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*8-1:0]            req_op,
  input  logic [NUM_REQ*REGION_WIDTH-1:0] req_region,
  input  logic [NUM_REQ*8-1:0]            req_arg_a,
  input  logic [NUM_REQ*8-1:0]            req_arg_b,
  output logic [NUM_REQ-1:0]              req_grant,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [7:0]                      rsp_module_id,
  output logic                            rsp_error,
  output logic [7:0]                      core_op,
  output logic [7:0]                      core_psplit_module_id,
  output logic [7:0]                      core_pmerge_m1,
  output logic [7:0]                      core_pmerge_m2,
  output logic [REGION_WIDTH-1:0]         core_pnew_region,
  output logic [REGION_WIDTH-1:0]         core_psplit_mask,
  output logic                            core_op_valid,
  input  logic                            core_op_done,
  input  logic [7:0]                      core_result_module_id,
  output logic                            busy,
  output logic [15:0]                     op_count,
  output logic [1:0]                      dbg_state
);

  // Handshake: req_valid[i] is held with its operands until req_grant[i] is seen
  // high in IDLE; the grant cycle is the accept cycle, and the response is a
  // single rsp_valid[i] pulse later. The core sees a one-cycle core_op_valid
  // strobe and answers with core_op_done sampled only in WAIT.

  localparam int         IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] OP_MAX = 8'h02;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, winner, win_idx, cand, rr_ptr_nxt;
  logic             any_req;
  logic             op_illegal;

`ifdef PARTITION_ARB_TIMEOUT_EN
  logic [15:0] wdog;
  logic        timed_out;
  assign timed_out = (wdog == 16'(TIMEOUT_CYCLES - 1));
`endif

  assign op_illegal = (core_op > OP_MAX);
  assign busy       = (state != S_IDLE);
  assign dbg_state  = state;

  // First requester found scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!any_req && req_valid[cand]) begin
        any_req = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign rr_ptr_nxt = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (any_req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = op_illegal ? S_RESP : S_WAIT;
      S_WAIT: begin
        if (core_op_done) state_nxt = S_RESP;
`ifdef PARTITION_ARB_TIMEOUT_EN
        else if (timed_out) state_nxt = S_RESP;
`endif
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_grant     = '0;
    rsp_valid     = '0;
    core_op_valid = rst_n && (state == S_ISSUE) && !op_illegal;
    if (rst_n && (state == S_IDLE) && any_req) req_grant[win_idx] = 1'b1;
    if (state == S_RESP) rsp_valid[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                 <= S_IDLE;
      rr_ptr                <= '0;
      winner                <= '0;
      op_count              <= '0;
      rsp_module_id         <= '0;
      rsp_error             <= 1'b0;
      core_op               <= '0;
      core_psplit_module_id <= '0;
      core_pmerge_m1        <= '0;
      core_pmerge_m2        <= '0;
      core_pnew_region      <= '0;
      core_psplit_mask      <= '0;
`ifdef PARTITION_ARB_TIMEOUT_EN
      wdog                  <= '0;
`endif
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE: begin
          if (any_req) begin
            winner                <= win_idx;
            rr_ptr                <= rr_ptr_nxt;
            core_op               <= req_op[8*win_idx +: 8];
            core_pnew_region      <= req_region[REGION_WIDTH*win_idx +: REGION_WIDTH];
            core_psplit_mask      <= req_region[REGION_WIDTH*win_idx +: REGION_WIDTH];
            core_psplit_module_id <= req_arg_a[8*win_idx +: 8];
            core_pmerge_m1        <= req_arg_a[8*win_idx +: 8];
            core_pmerge_m2        <= req_arg_b[8*win_idx +: 8];
          end
        end
        S_ISSUE: begin
`ifdef PARTITION_ARB_TIMEOUT_EN
          wdog <= '0;
`endif
          if (op_illegal) begin
            rsp_module_id <= 8'hFF;
            rsp_error     <= 1'b1;
          end
        end
        S_WAIT: begin
          if (core_op_done) begin
            rsp_module_id <= core_result_module_id;
            rsp_error     <= 1'b0;
          end
`ifdef PARTITION_ARB_TIMEOUT_EN
          else if (timed_out) begin
            rsp_module_id <= 8'hFF;
            rsp_error     <= 1'b1;
          end else begin
            wdog <= wdog + 16'd1;
          end
`endif
        end
        S_RESP:  op_count <= op_count + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_partition_op_arbiter.sv
// Directed bench for partition_op_arbiter: per-cycle vector table plus
// hand-written round-robin, PSPLIT/PMERGE, WAIT hold/timeout and reset sequences.
module tb_partition_op_arbiter;

  localparam int NR = 4;
  localparam int RW = 64;

  logic             clk, rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*8-1:0]  req_op, req_arg_a, req_arg_b;
  logic [NR*RW-1:0] req_region;
  logic [NR-1:0]    req_grant, rsp_valid;
  logic [7:0]       rsp_module_id;
  logic             rsp_error;
  logic [7:0]       core_op, core_psplit_module_id, core_pmerge_m1, core_pmerge_m2;
  logic [RW-1:0]    core_pnew_region, core_psplit_mask;
  logic             core_op_valid, core_op_done;
  logic [7:0]       core_result_module_id;
  logic             busy;
  logic [15:0]      op_count;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  partition_op_arbiter #(
    .NUM_REQ(NR), .REGION_WIDTH(RW), .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op), .req_region(req_region),
    .req_arg_a(req_arg_a), .req_arg_b(req_arg_b),
    .req_grant(req_grant), .rsp_valid(rsp_valid),
    .rsp_module_id(rsp_module_id), .rsp_error(rsp_error),
    .core_op(core_op), .core_psplit_module_id(core_psplit_module_id),
    .core_pmerge_m1(core_pmerge_m1), .core_pmerge_m2(core_pmerge_m2),
    .core_pnew_region(core_pnew_region), .core_psplit_mask(core_psplit_mask),
    .core_op_valid(core_op_valid), .core_op_done(core_op_done),
    .core_result_module_id(core_result_module_id),
    .busy(busy), .op_count(op_count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_op = '0; req_region = '0;
    req_arg_a = '0; req_arg_b = '0;
    core_op_done = 1'b0; core_result_module_id = '0;
  endtask

  task automatic check_reset_outputs();
    check("rst_grant", req_grant, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    check("rst_core_op_valid", core_op_valid, 0);
    check("rst_core_op", core_op, 0);
    check("rst_pnew_region", core_pnew_region, 0);
    check("rst_psplit_mask", core_psplit_mask, 0);
    check("rst_args", {core_psplit_module_id, core_pmerge_m1, core_pmerge_m2}, 0);
    check("rst_rsp_id_err", {rsp_module_id, rsp_error}, 0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    check_reset_outputs();
    rst_n = 1'b1;
    exp_count = 0;
  endtask

  // driver: one complete legal operation from requester idx
  task automatic run_op(input int idx, input logic [7:0] op, input logic [63:0] region,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] result);
    bit got;
    clear_inputs();
    req_valid[idx] = 1'b1;
    req_op[8*idx +: 8] = op;
    req_region[RW*idx +: RW] = region;
    req_arg_a[8*idx +: 8] = a;
    req_arg_b[8*idx +: 8] = b;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (req_grant != 0) got = 1;
      else step();
    end
    check("op_grant", req_grant, 64'd1 << idx);
    step();
    req_valid = '0;
    #1;
    check("op_issue_valid", core_op_valid, 1);
    check("op_core_op", core_op, op);
    case (op)
      8'h00: check("op_pnew_region", core_pnew_region, region);
      8'h01: begin
        check("op_psplit_mask", core_psplit_mask, region);
        check("op_psplit_id", core_psplit_module_id, a);
      end
      default: begin
        check("op_pmerge_m1", core_pmerge_m1, a);
        check("op_pmerge_m2", core_pmerge_m2, b);
      end
    endcase
    core_op_done = 1'b1;
    core_result_module_id = result;
    for (int c = 0; c < 20; c++) begin
      step();
      if (rsp_valid != 0) break;
    end
    core_op_done = 1'b0;
    check("op_rsp_valid", rsp_valid, 64'd1 << idx);
    check("op_rsp_error", rsp_error, 0);
    check("op_rsp_id", rsp_module_id, result);
    check("op_hold_core_op", core_op, op);
    exp_count++;
    step();
    check("op_count", op_count, exp_count);
    check("op_idle", busy, 0);
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] op;
    logic        done;
    logic [7:0]  result;
    logic [3:0]  e_grant;
    logic        e_opv;
    logic [3:0]  e_rsp;
    logic        e_err;
    logic [7:0]  e_id;
    logic        e_busy;
    logic [15:0] e_count;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic [3:0] valid, logic [31:0] op, logic done, logic [7:0] result,
                              logic [3:0] e_grant, logic e_opv, logic [3:0] e_rsp, logic e_err,
                              logic [7:0] e_id, logic e_busy, logic [15:0] e_count);
    vec_t v;
    v.valid = valid; v.op = op; v.done = done; v.result = result;
    v.e_grant = e_grant; v.e_opv = e_opv; v.e_rsp = e_rsp; v.e_err = e_err;
    v.e_id = e_id; v.e_busy = e_busy; v.e_count = e_count;
    return v;
  endfunction

  logic [3:0] exp_q[$];
  logic [3:0] last_grant;
  bit         pending;
  int         n;
  bit         hold_ok;

  initial begin
    rst_n = 1'b0;
    clear_inputs();

    // single PNEW from req 2, illegal op from req 3, done ignored outside WAIT,
    // round-robin between req 0 and req 1; region 0x7 on every slice
    vecs[0]  = mk(4'b0100, 32'h0, 0, 8'h00, 4'b0100, 0, 4'b0000, 0, 8'h00, 0, 0);
    vecs[1]  = mk(4'b0000, 32'h0, 0, 8'h00, 4'b0000, 1, 4'b0000, 0, 8'h00, 1, 0);
    vecs[2]  = mk(4'b0000, 32'h0, 1, 8'h2A, 4'b0000, 0, 4'b0000, 0, 8'h00, 1, 0);
    vecs[3]  = mk(4'b0000, 32'h0, 0, 8'h00, 4'b0000, 0, 4'b0100, 0, 8'h2A, 1, 0);
    vecs[4]  = mk(4'b0000, 32'h0, 0, 8'h00, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 1);
    vecs[5]  = mk(4'b1000, 32'h05000000, 0, 8'h00, 4'b1000, 0, 4'b0000, 0, 8'h00, 0, 1);
    vecs[6]  = mk(4'b0000, 32'h05000000, 0, 8'h00, 4'b0000, 0, 4'b0000, 0, 8'h00, 1, 1);
    vecs[7]  = mk(4'b0000, 32'h05000000, 0, 8'h00, 4'b0000, 0, 4'b1000, 1, 8'hFF, 1, 1);
    vecs[8]  = mk(4'b0000, 32'h0, 1, 8'h00, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 2);
    vecs[9]  = mk(4'b0011, 32'h0, 1, 8'h00, 4'b0001, 0, 4'b0000, 0, 8'h00, 0, 2);
    vecs[10] = mk(4'b0010, 32'h0, 1, 8'h00, 4'b0000, 1, 4'b0000, 0, 8'h00, 1, 2);
    vecs[11] = mk(4'b0010, 32'h0, 0, 8'h00, 4'b0000, 0, 4'b0000, 0, 8'h00, 1, 2);
    vecs[12] = mk(4'b0010, 32'h0, 1, 8'h11, 4'b0000, 0, 4'b0000, 0, 8'h00, 1, 2);
    vecs[13] = mk(4'b0010, 32'h0, 1, 8'h00, 4'b0000, 0, 4'b0001, 0, 8'h11, 1, 2);
    vecs[14] = mk(4'b0010, 32'h0, 0, 8'h00, 4'b0010, 0, 4'b0000, 0, 8'h00, 0, 3);
    vecs[15] = mk(4'b0000, 32'h0, 0, 8'h00, 4'b0000, 1, 4'b0000, 0, 8'h00, 1, 3);
    vecs[16] = mk(4'b0000, 32'h0, 1, 8'h22, 4'b0000, 0, 4'b0000, 0, 8'h00, 1, 3);
    vecs[17] = mk(4'b0000, 32'h0, 0, 8'h00, 4'b0000, 0, 4'b0010, 0, 8'h22, 1, 3);
    vecs[18] = mk(4'b0000, 32'h0, 0, 8'h00, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 4);

    do_reset();

    for (int i = 0; i < 19; i++) begin
      req_valid = vecs[i].valid;
      req_op = vecs[i].op;
      req_region = {NR{64'h7}};
      core_op_done = vecs[i].done;
      core_result_module_id = vecs[i].result;
      #1;
      check($sformatf("vec%0d_grant", i), req_grant, vecs[i].e_grant);
      check($sformatf("vec%0d_op_valid", i), core_op_valid, vecs[i].e_opv);
      if (vecs[i].e_opv) begin
        check($sformatf("vec%0d_core_op", i), core_op, 8'h00);
        check($sformatf("vec%0d_region", i), core_pnew_region, 64'h7);
      end
      check($sformatf("vec%0d_rsp_valid", i), rsp_valid, vecs[i].e_rsp);
      if (vecs[i].e_rsp != 0) begin
        check($sformatf("vec%0d_rsp_error", i), rsp_error, vecs[i].e_err);
        check($sformatf("vec%0d_rsp_id", i), rsp_module_id, vecs[i].e_id);
      end
      check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      check($sformatf("vec%0d_op_count", i), op_count, vecs[i].e_count);
      step();
    end

    // all four requesting continuously: grants 0,1,2,3,0, response before next grant
    do_reset();
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req_valid = 4'b1111;
    core_op_done = 1'b1;
    core_result_module_id = 8'h40;
    pending = 0;
    last_grant = '0;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      #1;
      if (rsp_valid != 0) begin
        check("rr_rsp_owner", rsp_valid, last_grant);
        pending = 0;
      end
      if (req_grant != 0) begin
        check("rr_rsp_before_grant", pending, 0);
        check("rr_grant_order", req_grant, exp_q.pop_front());
        last_grant = req_grant;
        pending = 1;
      end
      step();
    end
    check("rr_all_grants_seen", exp_q.size(), 0);

    // PSPLIT then PMERGE from requester 1
    do_reset();
    run_op(1, 8'h01, 64'h1, 8'h00, 8'h00, 8'h05);
    run_op(1, 8'h02, 64'h0, 8'h01, 8'h02, 8'h06);
    check("split_merge_count", op_count, 2);

    // requester 1 op with the core never answering
    do_reset();
    req_valid = 4'b0010;
    #1;
    check("hang_grant", req_grant, 4'b0010);
    step();
    req_valid = '0;
    step();
`ifdef PARTITION_ARB_TIMEOUT_EN
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid != 0) break;
      n++;
      step();
    end
    check("timeout_wait_cycles", n, 10);
    check("timeout_rsp_valid", rsp_valid, 4'b0010);
    check("timeout_rsp_error", rsp_error, 1);
    check("timeout_rsp_id", rsp_module_id, 8'hFF);
    step();
    check("timeout_op_count", op_count, 1);
    req_valid = 4'b0010;
    #1;
    check("timeout_regrant", req_grant, 4'b0010);
    step();
    req_valid = '0;
    step();
`else
    hold_ok = 1;
    for (int c = 0; c < 1000; c++) begin
      if (!busy || rsp_valid != 0) hold_ok = 0;
      step();
    end
    check("hang_busy_1000", hold_ok, 1);
`endif

    // one-cycle reset in WAIT abandons the op and restarts round-robin at 0
    rst_n = 1'b0;
    step();
    check_reset_outputs();
    rst_n = 1'b1;
    req_valid = 4'b1010;
    #1;
    check("post_rst_grant", req_grant, 4'b0010);
    check("post_rst_no_rsp", rsp_valid, 0);
    step();
    clear_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/partition_op_arbiter.md
PARTITION_OP_ARBITER -- requirements
Module: partition_op_arbiter

Interface
REQ-001 Param NUM_REQ, default 4, number of requesters sharing one partition_core.
REQ-002 Param REGION_WIDTH, default 64, region/mask width; matches partition_core.
REQ-003 Param TIMEOUT_CYCLES, default 255, watchdog limit in WAIT (used only with REQ-030).
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 req_valid  in  NUM_REQ  per-requester request; held with args until granted.
REQ-007 req_op  in  NUM_REQ*8  opcode per requester, slice i = [8i+7:8i]; 0x00 PNEW, 0x01 PSPLIT, 0x02 PMERGE.
REQ-008 req_region  in  NUM_REQ*REGION_WIDTH  PNEW region or PSPLIT mask.
REQ-009 req_arg_a / req_arg_b  in  NUM_REQ*8 each  PSPLIT module id or PMERGE m1 / PMERGE m2.
REQ-010 req_grant  out  NUM_REQ  one-hot; high in the cycle a request is accepted.
REQ-011 rsp_valid  out  NUM_REQ  one-hot one-cycle completion pulse to the granted requester.
REQ-012 rsp_module_id  out  8  core result_module_id captured at completion; 0xFF on error.
REQ-013 rsp_error  out  1  qualified by rsp_valid; 1 = illegal opcode or timeout.
REQ-014 core_op, core_psplit_module_id, core_pmerge_m1, core_pmerge_m2  out  8 each; core_pnew_region, core_psplit_mask  out  REGION_WIDTH  registered core operands.
REQ-015 core_op_valid  out  1  one-cycle issue strobe to the core.
REQ-016 core_op_done, core_result_module_id  in  1, 8  core completion and result.
REQ-017 busy  out  1  high in any state except IDLE; op_count  out  16  completed ops (including errors), wraps at 0xFFFF.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: if any req_valid, select winner by round-robin from pointer rr_ptr, assert req_grant[winner] combinationally that cycle, latch winner's operands on that edge, go to ISSUE; otherwise stay.
REQ-020 Round-robin: search order rr_ptr, rr_ptr+1, ... mod NUM_REQ; on grant, rr_ptr <= winner+1 mod NUM_REQ.
REQ-021 ISSUE: if latched opcode > 0x02, core_op_valid stays 0 and the FSM goes to RESP with error; otherwise core_op_valid=1 for exactly this cycle, then WAIT.
REQ-022 WAIT: core_op_done is sampled from the cycle after ISSUE onward; when high, capture core_result_module_id and go to RESP.
REQ-023 RESP: rsp_valid[winner]=1 for one cycle with rsp_module_id/rsp_error; op_count increments; next state IDLE.
REQ-024 Latency: grant at cycle T, core_op_valid at T+1, earliest rsp_valid at T+3 (op_done in T+2); back-to-back grant no earlier than the cycle after RESP.
REQ-025 core_op_done in IDLE, ISSUE or RESP is ignored.
REQ-026 A requester dropping req_valid before grant is not served; req_valid after grant is a new request.
REQ-027 Core operand outputs hold their latched values from ISSUE through RESP.

Reset
REQ-028 While rst_n=0 at posedge: state=IDLE, rr_ptr=0, op_count=0, all core operand outputs 0, core_op_valid=0, req_grant=0, rsp_valid=0, rsp_module_id=0, rsp_error=0, busy=0.
REQ-029 Reset asserted mid-operation abandons it with no rsp_valid; the core is reset separately.

Configuration
REQ-030 Macro PARTITION_ARB_TIMEOUT_EN defined: 16-bit watchdog cleared on entering WAIT, counting each WAIT cycle; when it reaches TIMEOUT_CYCLES without op_done, go to RESP with rsp_error=1, rsp_module_id=0xFF. Undefined: no counter; WAIT holds indefinitely.

Verification
REQ-031 Single request: req_valid[2], PNEW region 0x7 -> req_grant=0b0100, one core_op_valid with core_op=0x00 and region 0x7, rsp_valid=0b0100, rsp_error=0, op_count=1.
REQ-032 All four requesting continuously after reset -> grant order 0,1,2,3,0; each requester's rsp_valid precedes the next grant.
REQ-033 PSPLIT arg_a=0 mask 0x1 then PMERGE arg_a=1 arg_b=2 from requester 1 -> core_psplit_mask=0x1, then core_pmerge_m1=1, core_pmerge_m2=2; two responses, op_count=2.
REQ-034 Opcode 0x05 from requester 3 -> no core_op_valid pulse; rsp_valid=0b1000, rsp_error=1, rsp_module_id=0xFF, two cycles after grant.
REQ-035 With PARTITION_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=10, core_op_done tied 0 -> rsp_error=1 after 10 WAIT cycles; without the macro, busy stays 1 for 1000 cycles.
REQ-036 rst_n low for one cycle during WAIT -> no rsp_valid; all outputs at reset values the next cycle; the next request is served from rr_ptr=0.
